// File: rtl/mapu_host_if.sv
// Host <-> matrix engine link: operation control, operand row stream out, result row stream back.
interface mapu_host_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  o_mapu_en;
  logic                  o_mapu_op;
  logic                  o_tx_vld;
  logic                  i_tx_rdy;
  logic [DATA_WIDTH-1:0] o_tx_r0;
  logic [DATA_WIDTH-1:0] o_tx_r1;
  logic [DATA_WIDTH-1:0] o_tx_r2;
  logic [DATA_WIDTH-1:0] o_tx_r3;
  logic                  i_rx_vld;
  logic                  o_rx_rdy;
  logic [DATA_WIDTH-1:0] i_rx_r0;
  logic [DATA_WIDTH-1:0] i_rx_r1;
  logic [DATA_WIDTH-1:0] i_rx_r2;
  logic [DATA_WIDTH-1:0] i_rx_r3;
  logic                  i_rx_of;

  modport master (
    output o_mapu_en, o_mapu_op, o_tx_vld, o_tx_r0, o_tx_r1, o_tx_r2, o_tx_r3, o_rx_rdy,
    input  i_tx_rdy, i_rx_vld, i_rx_r0, i_rx_r1, i_rx_r2, i_rx_r3, i_rx_of
  );

  modport slave (
    input  o_mapu_en, o_mapu_op, o_tx_vld, o_tx_r0, o_tx_r1, o_tx_r2, o_tx_r3, o_rx_rdy,
    output i_tx_rdy, i_rx_vld, i_rx_r0, i_rx_r1, i_rx_r2, i_rx_r3, i_rx_of
  );
endinterface

// File: rtl/mapu_host.sv
// Matrix engine host: buffers operands A/B, streams 8 rows to the engine, collects 4 result rows
// with an idle timeout, and flags overflow from the engine or from result MSBs.
module mapu_host #(
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_wr_en,
  input  logic [4:0]            i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [3:0]            i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  input  logic                  i_start,
  input  logic                  i_op,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_of,
  output logic                  o_err,
  mapu_host_if.master           eng
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

  state_t state, state_nx;

  logic [7:0][3:0][DATA_WIDTH-1:0] op_buf;
  logic [3:0][3:0][DATA_WIDTH-1:0] res_buf;
  logic [2:0]    tx_row;
  logic [1:0]    rx_row;
  logic [TW-1:0] tmo_cnt;
  logic          sticky_of;
  logic          mapu_op_q;
  logic          of_q;
  logic          err_q;
  logic          tx_acc;
  logic          rx_acc;
  logic          tmo_hit;
  logic          msb_any;

  assign tx_acc  = (state == SEND) && eng.i_tx_rdy;
  assign rx_acc  = (state == RECV) && eng.i_rx_vld;
  // the cycle that would bring the idle count up to TIMEOUT_CYC ends the wait
  assign tmo_hit = (state == RECV) && !eng.i_rx_vld && (tmo_cnt == TMO_LAST);

  always_comb begin
    msb_any = 1'b0;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        msb_any = msb_any | res_buf[r[1:0]][c[1:0]][DATA_WIDTH-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    o_busy        = 1'b0;
    o_done        = 1'b0;
    eng.o_mapu_en = 1'b0;
    eng.o_tx_vld  = 1'b0;
    eng.o_rx_rdy  = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) state_nx = SEND;
      end
      SEND: begin
        o_busy        = 1'b1;
        eng.o_mapu_en = 1'b1;
        eng.o_tx_vld  = 1'b1;
        if (tx_acc && (tx_row == 3'd7)) state_nx = RECV;
      end
      RECV: begin
        o_busy        = 1'b1;
        eng.o_mapu_en = 1'b1;
        eng.o_rx_rdy  = 1'b1;
        if ((rx_acc && (rx_row == 2'd3)) || tmo_hit) state_nx = DONE;
      end
      DONE: begin
        o_busy   = 1'b1;
        o_done   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_buf    <= '0;
      res_buf   <= '0;
      tx_row    <= '0;
      rx_row    <= '0;
      tmo_cnt   <= '0;
      sticky_of <= 1'b0;
      mapu_op_q <= 1'b0;
      of_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // a write in the start cycle lands before SEND reads the buffer
          if (i_wr_en) op_buf[i_wr_addr[4:2]][i_wr_addr[1:0]] <= i_wr_data;
          if (i_start) begin
            mapu_op_q <= i_op;
            of_q      <= 1'b0;
            err_q     <= 1'b0;
            tx_row    <= '0;
            sticky_of <= 1'b0;
          end
        end
        SEND: begin
          if (tx_acc) begin
            tx_row <= tx_row + 3'd1;
            if (tx_row == 3'd7) begin
              rx_row  <= '0;
              tmo_cnt <= '0;
            end
          end
        end
        RECV: begin
          if (rx_acc) begin
            res_buf[rx_row] <= {eng.i_rx_r3, eng.i_rx_r2, eng.i_rx_r1, eng.i_rx_r0};
            sticky_of       <= sticky_of | eng.i_rx_of;
            rx_row          <= rx_row + 2'd1;
            tmo_cnt         <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_hit) err_q <= 1'b1;
          end
        end
        DONE: of_q <= sticky_of | msb_any;
        default: ;
      endcase
    end
  end

  assign eng.o_mapu_op = mapu_op_q;
  assign eng.o_tx_r0   = op_buf[tx_row][0];
  assign eng.o_tx_r1   = op_buf[tx_row][1];
  assign eng.o_tx_r2   = op_buf[tx_row][2];
  assign eng.o_tx_r3   = op_buf[tx_row][3];
  assign o_rd_data     = res_buf[i_rd_addr[3:2]][i_rd_addr[1:0]];
  assign o_of          = of_q;
  assign o_err         = err_q;
endmodule

// File: tb/tb_mapu_host.sv
// Randomized bench for mapu_host: an engine model answers the row stream, a scoreboard checks rows,
// completion flags and result reads against expectations computed from matrix arithmetic.
module tb_mapu_host;
  localparam int DW  = 32;
  localparam int TMO = 16;

  typedef logic [3:0][DW-1:0] row_t;
  typedef struct packed {logic of; logic err;} done_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_wr_en = 1'b0;
  logic [4:0]    i_wr_addr = '0;
  logic [DW-1:0] i_wr_data = '0;
  logic [3:0]    i_rd_addr = '0;
  logic [DW-1:0] o_rd_data;
  logic          i_start = 1'b0;
  logic          i_op = 1'b0;
  logic          o_busy, o_done, o_of, o_err;

  mapu_host_if #(.DATA_WIDTH(DW)) eng();

  mapu_host #(.DATA_WIDTH(DW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
    .i_start(i_start), .i_op(i_op),
    .o_busy(o_busy), .o_done(o_done), .o_of(o_of), .o_err(o_err),
    .eng(eng)
  );

  always #5 clk = ~clk;

  int unsigned tcyc = 0;
  always @(posedge clk) tcyc <= tcyc + 1;

  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;
  int done_exp_cnt = 0;
  int done_cyc = 0;

  row_t  ref_op [8];
  row_t  ref_res [4];
  row_t  exp_tx [$];
  done_t exp_done [$];
  logic [DW-1:0] exp_rd [$];
  logic  rd_chk = 1'b0;

  task automatic chk(input string nm, input logic [4*DW-1:0] act, input logic [4*DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: samples on the falling edge
  initial begin
    row_t  cur, prev_row, e;
    done_t d;
    logic  prev_stall = 1'b0;
    logic  of_pend = 1'b0;
    logic  of_exp = 1'b0;
    logic [DW-1:0] er;
    forever begin
      @(negedge clk);
      cur = {eng.o_tx_r3, eng.o_tx_r2, eng.o_tx_r1, eng.o_tx_r0};
      if (of_pend) begin
        chk("of_after_done", o_of, of_exp);
        of_pend = 1'b0;
      end
      if (prev_stall && eng.o_tx_vld) chk("tx_hold", cur, prev_row);
      if (eng.o_tx_vld && eng.i_tx_rdy) begin
        if (exp_tx.size() == 0) chk("tx_unexpected_row", 1, 0);
        else begin
          e = exp_tx.pop_front();
          chk("tx_row", cur, e);
        end
      end
      prev_stall = eng.o_tx_vld && !eng.i_tx_rdy;
      prev_row   = cur;
      if (o_done) begin
        done_cnt++;
        done_cyc = tcyc;
        if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          d = exp_done.pop_front();
          chk("err_at_done", o_err, d.err);
          chk("busy_at_done", o_busy, 1);
          of_pend = 1'b1;
          of_exp  = d.of;
        end
      end
      if (rd_chk) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          er = exp_rd.pop_front();
          chk("rd_data", o_rd_data, er);
        end
      end
    end
  end

  task automatic wr(input logic [4:0] a, input logic [DW-1:0] dat);
    i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = dat;
    ref_op[a[4:2]][a[1:0]] = dat;
    @(posedge clk); #1;
    i_wr_en = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) begin
      i_rd_addr = 4'(a);
      exp_rd.push_back(ref_res[a / 4][a % 4]);
      rd_chk = 1'b1;
      @(posedge clk); #1;
    end
    rd_chk = 1'b0;
  endtask

  task automatic clear_ref();
    for (int r = 0; r < 8; r++) ref_op[r] = '0;
    for (int r = 0; r < 4; r++) ref_res[r] = '0;
  endtask

  // tx_mode: 0 always ready, 1 three-cycle stall on row 2, 2 random ready
  task automatic run_txn(input logic op, input int tx_mode, input int nrows, input logic force_of,
                         input logic rand_of, input logic ign_cmds, input logic simul_wr,
                         input logic do_reset);
    row_t res [4];
    logic [3:0] rof;
    logic eof, rdy, vld;
    logic [4:0] a;
    logic [DW-1:0] dv;
    int acc, cyc, stall, sent, cap_cyc, delta;
    bit seen;
    if (simul_wr) begin
      a = 5'($urandom); dv = $urandom;
      i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = dv;
      ref_op[a[4:2]][a[1:0]] = dv;
    end
    i_start = 1'b1; i_op = op;
    for (int r = 0; r < 8; r++) exp_tx.push_back(ref_op[r]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        res[r][c] = op ? ref_op[r][c] * ref_op[r+4][c] : ref_op[r][c] + ref_op[r+4][c];
    if (force_of) res[1][2] = 32'h8000_0000;
    for (int r = 0; r < 4; r++) rof[r] = rand_of ? ($urandom_range(0, 5) == 0) : 1'b0;
    eof = 1'b0;
    for (int r = 0; r < nrows; r++) begin
      ref_res[r] = res[r];
      eof = eof | rof[r];
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) eof = eof | ref_res[r][c][DW-1];
    if (!do_reset) begin
      exp_done.push_back(done_t'{of: eof, err: (nrows < 4)});
      done_exp_cnt++;
    end
    @(posedge clk); #1;
    i_start = 1'b0; i_wr_en = 1'b0;
    chk("busy_after_start", o_busy, 1);
    chk("of_clr_after_start", o_of, 0);
    chk("err_clr_after_start", o_err, 0);
    chk("tx_vld_first_cycle", eng.o_tx_vld, 1);
    chk("mapu_op", eng.o_mapu_op, op);
    chk("mapu_en_send", eng.o_mapu_en, 1);

    acc = 0; cyc = 0; stall = 0;
    while (acc < 8 && cyc < 200) begin
      case (tx_mode)
        0:       rdy = 1'b1;
        1:       rdy = !(acc == 2 && stall < 3);
        default: rdy = ($urandom_range(0, 2) != 0);
      endcase
      eng.i_tx_rdy = rdy;
      if (ign_cmds) begin
        i_wr_en = 1'($urandom); i_wr_addr = 5'($urandom); i_wr_data = $urandom;
        i_start = 1'($urandom); i_op = 1'($urandom);
      end
      @(negedge clk);
      if (eng.o_tx_vld && eng.i_tx_rdy) acc++;
      else if (!rdy) stall++;
      cyc++;
      @(posedge clk); #1;
    end
    i_wr_en = 1'b0; i_start = 1'b0;
    eng.i_tx_rdy = 1'b1;
    chk("tx_accepts", acc, 8);
    if (tx_mode == 0) chk("tx_consecutive", cyc, 8);
    if (tx_mode == 1) chk("tx_stall_cycles", stall, 3);
    chk("tx_vld_drop", eng.o_tx_vld, 0);
    chk("rx_rdy_recv", eng.o_rx_rdy, 1);
    chk("mapu_op_held", eng.o_mapu_op, op);

    sent = 0; cyc = 0; cap_cyc = 0;
    while (sent < nrows && cyc < 200) begin
      if (do_reset && sent == 1) break;
      vld = (tx_mode == 0) ? 1'b1 : ($urandom_range(0, 3) == 0 ? 1'b0 : 1'b1);
      eng.i_rx_vld = vld;
      eng.i_rx_r0 = res[sent][0]; eng.i_rx_r1 = res[sent][1];
      eng.i_rx_r2 = res[sent][2]; eng.i_rx_r3 = res[sent][3];
      eng.i_rx_of = rof[sent];
      @(negedge clk);
      if (eng.i_rx_vld && eng.o_rx_rdy) begin
        sent++;
        cap_cyc = tcyc;
      end
      cyc++;
      @(posedge clk); #1;
    end
    eng.i_rx_vld = 1'b0; eng.i_rx_of = 1'b0;

    if (do_reset) begin
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      clear_ref();
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_of", o_of, 0);
      chk("rst_err", o_err, 0);
      chk("rst_mapu_en", eng.o_mapu_en, 0);
      chk("rst_mapu_op", eng.o_mapu_op, 0);
      chk("rst_tx_vld", eng.o_tx_vld, 0);
      chk("rst_rx_rdy", eng.o_rx_rdy, 0);
      repeat (TMO + 4) @(posedge clk);
      #1;
      chk("rst_no_done", done_cnt, done_exp_cnt);
      return;
    end

    chk("rx_rows_sent", sent, nrows);
    seen = 0;
    for (int i = 0; i < TMO + 10 && !seen; i++) begin
      @(negedge clk);
      if (o_done) seen = 1;
      @(posedge clk); #1;
    end
    chk("done_seen", seen, 1);
    delta = done_cyc - cap_cyc;
    if (nrows == 4) chk("done_latency", delta, 1);
    else chk("timeout_latency", (delta >= TMO && delta <= TMO + 1), 1);
    chk("idle_after_done", o_busy, 0);
    chk("done_one_cycle", o_done, 0);
    read_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1);
  end

  initial begin
    eng.i_tx_rdy = 1'b1; eng.i_rx_vld = 1'b0; eng.i_rx_of = 1'b0;
    eng.i_rx_r0 = '0; eng.i_rx_r1 = '0; eng.i_rx_r2 = '0; eng.i_rx_r3 = '0;
    clear_ref();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", o_busy, 0);
    chk("reset_done", o_done, 0);
    chk("reset_of", o_of, 0);
    chk("reset_err", o_err, 0);
    chk("reset_mapu_en", eng.o_mapu_en, 0);
    chk("reset_tx_vld", eng.o_tx_vld, 0);
    chk("reset_rx_rdy", eng.o_rx_rdy, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    read_all();

    // A all 1, B all 2, add, full-rate handshakes
    for (int a = 0; a < 32; a++) wr(5'(a), (a < 16) ? 32'd1 : 32'd2);
    run_txn(1'b0, 0, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // tx backpressure on row 2
    for (int a = 0; a < 32; a++) wr(5'(a), 32'($urandom_range(0, 1000)));
    run_txn(1'b0, 1, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // MSB of result [1][2] drives the overflow flag
    for (int a = 0; a < 32; a++) wr(5'(a), 32'(a + 1));
    run_txn(1'b0, 0, 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 4; k++) wr(5'($urandom), $urandom);
      run_txn(1'($urandom), 2, 4, 1'b0, 1'b1, 1'($urandom), 1'($urandom), 1'b0);
    end

    // engine stalls after two rows
    for (int k = 0; k < 4; k++) wr(5'($urandom), 32'($urandom_range(0, 255)));
    run_txn(1'b1, 2, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    run_txn(1'b1, 2, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    read_all();

    run_txn(1'b0, 0, 4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("tx_queue_drained", exp_tx.size(), 0);
    chk("done_queue_drained", exp_done.size(), 0);
    chk("done_count", done_cnt, done_exp_cnt);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
